// File: rtl/parity_serial_rx.sv
// parity_serial_rx: receiver for the single-wire serial pin link.
// Frame: start (0), DATA_BITS data bits LSB first, even parity bit, stop (1).
// The line is synchronised with two flops and sampled mid-bit by a down-counter
// that runs at CLKS_PER_BIT clocks per bit. Each finished word is held in a
// one-entry register and offered on a valid/ready interface.
//
// Ports:
//   clk          system clock (rising edge)
//   rst_n        async active-low reset
//   rx_i         serial line, idle high, asynchronous to clk
//   data_o       received word
//   valid_o      data_o / parity_err_o / frame_err_o are valid
//   ready_i      consumer accepts when valid_o & ready_i
//   parity_err_o parity check failed for the held word
//   frame_err_o  stop bit sampled low for the held word
//   overrun_o    one-cycle pulse: a completed frame was dropped
//   busy_o       receiver is not idle
module parity_serial_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick;

  // Synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;

    if (state_q != StIdle && state_q != StWaitHigh) begin
      cnt_d = tick ? BitLoad : cnt_q - 1'b1;
    end

    // Handshake empties the holding register; a completion below may refill it.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = rx_s_q ? StIdle : StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d                = shift_q >> 1;
          shift_d[DATA_BITS-1]   = rx_s_q;
          bit_d                  = bit_q + 1'b1;
          if (bit_q == LastBit) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (tick) begin
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (!valid_q || ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = par_bad_q;
            ferr_d  = !rx_s_q;
          end else begin
            ovr_d = 1'b1;
          end
          // A held-low line must go high before another start can be seen.
          state_d = rx_s_q ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Testbench for parity_serial_rx: frames are generated at the bit level from
// (data, parity, stop) values; expected words go into a queue that a negedge
// monitor drains on every valid/ready handshake.
module tb_parity_serial_rx;

  localparam int unsigned DB  = 8;
  localparam int unsigned CPB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_i = 1'b1;
  logic          ready_i = 1'b0;
  logic [DB-1:0] data_o;
  logic          valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  parity_serial_rx #(
    .DATA_BITS    (DB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   valid_rises = 0;
  int   valid_hi = 0;
  int   ovr_cnt = 0;
  int   last_rise_cyc = 0;
  int   start_cyc = 0;
  bit   rand_ready = 1'b0;
  bit   ready_val = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    #1;
    ready_i = rand_ready ? 1'($urandom % 2) : ready_val;
  end

  // Monitor / scoreboard.
  logic          prev_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DB-1:0] held_d;
  logic          held_pe, held_fe;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (overrun_o) ovr_cnt++;
      if (valid_o) begin
        valid_hi++;
        if (!prev_valid) begin
          valid_rises++;
          last_rise_cyc = cyc;
        end
        if (prev_stall) begin
          chk("stable_data", data_o, held_d);
          chk("stable_flags", {parity_err_o, frame_err_o}, {held_pe, held_fe});
        end
        if (ready_i) begin
          if (q.size() == 0) begin
            chk("unexpected_word", data_o, 32'hdead);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("data", data_o, e.d);
            chk("parity_err", parity_err_o, e.pe);
            chk("frame_err", frame_err_o, e.fe);
          end
        end
      end
      prev_valid = valid_o;
      prev_stall = valid_o && !ready_i;
      held_d     = data_o;
      held_pe    = parity_err_o;
      held_fe    = frame_err_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; leaves rx_i at the stop level. abort_bit >= 0 stops
  // halfway through that data bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop,
                            input int abort_bit);
    tick();
    start_cyc = cyc;
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < DB; i++) begin
      rx_i = d[i];
      if (i == abort_bit) begin
        repeat (CPB / 2) tick();
        return;
      end
      repeat (CPB) tick();
    end
    rx_i = p;
    repeat (CPB) tick();
    rx_i = stop;
    repeat (CPB) tick();
  endtask

  // Reference: even parity over data plus parity bit; stop must be 1.
  function automatic exp_t model(input logic [DB-1:0] d, input logic p, input logic stop);
    exp_t e;
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    ones += int'(p);
    e.d  = d;
    e.pe = (ones % 2) != 0;
    e.fe = !stop;
    return e;
  endfunction

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int r0, v0, o0, rise;
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_perr", parity_err_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    tick();
    rst_n = 1'b1;
    idle(5);

    // Clean frame: latency and single-cycle valid.
    ready_val = 1'b1;
    v0 = valid_hi;
    q.push_back(model(8'hA5, 1'b0, 1'b1));
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(20);
    chk("latency", last_rise_cyc - start_cyc, 171);
    chk("valid_width", valid_hi - v0, 1);
    drain();

    // Wrong parity.
    q.push_back(model(8'h01, 1'b0, 1'b1));
    send_frame(8'h01, 1'b0, 1'b1, -1);
    idle(20);
    drain();

    // Framing error with the line held low afterwards.
    r0 = valid_rises;
    q.push_back(model(8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (40) tick();
    chk("wait_high_busy", busy_o, 1);
    rise = cyc;
    rx_i = 1'b1;
    wait_cyc(rise + 2);
    chk("busy_before_release", busy_o, 1);
    wait_cyc(rise + 3);
    chk("busy_after_release", busy_o, 0);
    idle(200);
    chk("no_retrigger", valid_rises - r0, 1);
    drain();

    // False start: 4 low cycles.
    r0 = valid_rises;
    tick();
    rise = cyc;
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    wait_cyc(rise + 10);
    chk("false_start_busy", busy_o, 1);
    wait_cyc(rise + 11);
    chk("false_start_idle", busy_o, 0);
    idle(200);
    chk("false_start_no_word", valid_rises - r0, 0);

    // Overrun: consumer stalled across two back-to-back frames.
    ready_val = 1'b0;
    o0 = ovr_cnt;
    q.push_back(model(8'h11, 1'b0, 1'b1));
    send_frame(8'h11, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1);
    idle(10);
    @(negedge clk);
    chk("ovr_valid_held", valid_o, 1);
    chk("ovr_data_held", data_o, 8'h11);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    tick();
    ready_val = 1'b1;
    r0 = valid_rises;
    idle(20);
    drain();
    chk("ovr_no_second_word", valid_rises - r0, 0);

    // Reset during data bit 3.
    send_frame(8'h77, 1'b0, 1'b1, 3);
    rx_i = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_flags", {parity_err_o, frame_err_o, overrun_o}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    idle(300);
    chk("midrst_no_partial", valid_o, 0);
    q.push_back(model(8'h5A, 1'b0, 1'b1));
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    idle(20);
    drain();

    // Randomized frames with a randomly stalling consumer.
    rand_ready = 1'b1;
    o0 = ovr_cnt;
    for (int n = 0; n < 24; n++) begin
      logic [DB-1:0] d;
      logic p, s;
      d = DB'($urandom);
      p = 1'($urandom % 2);
      s = ($urandom % 4) != 0;
      q.push_back(model(d, p, s));
      send_frame(d, p, s, -1);
      idle(3 + int'($urandom % 20));
    end
    idle(40);
    drain();
    chk("random_no_overrun", ovr_cnt - o0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Receiver end of the single-wire serial pin link used between test devices.
- Frame format: start bit (0), DATA_BITS data bits LSB first, one even-parity bit, one stop bit (1).
- Samples one device pin with a 2-flop synchroniser and recovers each frame by oversampling.
- Presents each received word with parity and framing status on a valid/ready interface to the core logic.

Parameters:
DATA_BITS, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clk cycles per serial bit (even, >= 4)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk
rx_i  input  1  serial line from the pin; idle high; asynchronous to clk
data_o  output  DATA_BITS  received word
valid_o  output  1  data_o, parity_err_o and frame_err_o are valid
ready_i  input  1  consumer accepts the word when valid_o and ready_i are both high
parity_err_o  output  1  parity check failed for the word held in data_o
frame_err_o  output  1  stop bit sampled as 0 for the word held in data_o
overrun_o  output  1  one-cycle pulse: a completed frame was dropped
busy_o  output  1  high whenever the state is not IDLE

Behaviour:
- Reset: synchroniser flops = 1, state = IDLE, bit counter = 0, all outputs = 0 (data_o = 0).
- Reset mid-frame aborts the frame immediately. No partial word is delivered after release.
- Synchroniser: rx_s is rx_i delayed by 2 flops. All decisions use rx_s only.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: a falling edge of rx_s (previous 1, current 0) at cycle t0 moves the state to START and loads the counter with CLKS_PER_BIT/2-1.
- Counter behaviour: decrements every cycle. Sampling happens when the counter reaches 0, which reloads it with CLKS_PER_BIT-1.
- START sample at t0+CLKS_PER_BIT/2:
  - rx_s = 1: false start, go to IDLE.
  - rx_s = 0: go to DATA.
- DATA: bit i is sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shifted in LSB first. After bit DATA_BITS-1, go to PARITY.
- PARITY: sample p. Parity error = XOR-reduce(data) ^ p ≠ 0.
- STOP sample at t0+CLKS_PER_BIT/2+(DATA_BITS+2)*CLKS_PER_BIT:
  - Completion is evaluated on this cycle.
  - rx_s = 1: go to IDLE.
  - rx_s = 0: go to WAIT_HIGH, which returns to IDLE only when rx_s = 1. This prevents a held-low line from retriggering.
- Completion when the holding register is empty (valid_o = 0), or is being emptied this cycle (valid_o & ready_i):
  - The next cycle has data_o = word, valid_o = 1, and parity_err_o / frame_err_o set to this frame's status.
- Completion when valid_o = 1 and ready_i = 0:
  - The new word is dropped and the held word is unchanged.
  - overrun_o pulses high for exactly one cycle.
- valid_o stays high until the cycle after the handshake. data_o and the status bits are stable while valid_o is high. The status bits clear together with valid_o.
- Total latency from the rx_i start edge to valid_o is 2 + CLKS_PER_BIT/2 + (DATA_BITS+2)*CLKS_PER_BIT + 1 cycles. With defaults this is 171.
- Counters are sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1). There is no wrap outside the described reloads.

Test Plan:
- Defaults, frame 0xA5 with p=0 and stop=1, ready_i=1 -> data_o=0xA5, valid_o high for exactly 1 cycle, 171 cycles after the start edge; parity_err_o=0, frame_err_o=0.
- Frame 0x01 with p=0 (wrong) -> data_o=0x01, parity_err_o=1, frame_err_o=0.
- Frame 0x3C with p=0 and stop=0, line held low for 40 more cycles then high -> frame_err_o=1; busy_o stays high until 3 cycles after the line goes high; no second frame is received.
- rx_i low for 4 cycles, then high -> no valid_o; busy_o returns to 0 at the start sample (t0+8).
- ready_i=0, two back-to-back frames 0x11 then 0x22 -> data_o stays 0x11 with valid_o held; overrun_o pulses once at the second completion; raising ready_i gives 0x11 only.
- rst_n pulled low during bit 3 of a frame, then released, followed by a clean 0x5A frame -> all outputs 0 during reset; only 0x5A is delivered, with no errors.
